// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: command, ALU-side and result channels of the ALU issue stage
interface alu_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_opcode;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       alu_start;
  logic [1:0] alu_opcode;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_done;
  logic [7:0] alu_result;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [1:0] res_opcode;
  logic       res_err;
  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_done, alu_result, res_ready,
    output cmd_ready, alu_start, alu_opcode, alu_a, alu_b, res_valid, res_data, res_opcode, res_err
  );
  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_done, alu_result, res_ready,
    input  cmd_ready, alu_start, alu_opcode, alu_a, alu_b, res_valid, res_data, res_opcode, res_err
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU commands, issues them one at a time and registers the results
module alu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input logic              clk,
  input logic              reset,
  alu_cmd_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, WAIT, HOLD} state_t;
  state_t        state_q, state_d;
  logic [17:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          push, pop;
  logic [17:0]   head;
  logic [CW-1:0] tmo_q, tmo_d;
  logic          start_q, start_d;
  logic [1:0]    op_q, op_d;
  logic [7:0]    a_q, a_d, b_q, b_d;
  logic          rv_q, rv_d;
  logic [7:0]    rdata_q, rdata_d;
  logic [1:0]    rop_q, rop_d;
  logic          rerr_q, rerr_d;
  assign push           = bus.cmd_valid && bus.cmd_ready;
  assign head           = mem_q[rd_q];
  assign bus.cmd_ready  = cnt_q != (AW+1)'(DEPTH);
  assign bus.alu_start  = start_q;
  assign bus.alu_opcode = op_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.res_valid  = rv_q;
  assign bus.res_data   = rdata_q;
  assign bus.res_opcode = rop_q;
  assign bus.res_err    = rerr_q;
  // FIFO storage: {opcode, a, b} written at the tail
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {bus.cmd_opcode, bus.cmd_a, bus.cmd_b};
  end
  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(push);
      rd_q  <= rd_q + AW'(pop);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // FSM and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      start_q <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rv_q    <= 1'b0;
      rdata_q <= '0;
      rop_q   <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      start_q <= start_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
      rop_q   <= rop_d;
      rerr_q  <= rerr_d;
    end
  end
  // Next state: divide-by-zero is screened at pop, stale done is ignored in SETTLE, done beats timeout
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    start_d = 1'b0;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rv_d    = rv_q;
    rdata_d = rdata_q;
    rop_d   = rop_q;
    rerr_d  = rerr_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (cnt_q != '0 && !rv_q) begin
        pop              = 1'b1;
        {op_d, a_d, b_d} = head;
        if (head[17:16] == 2'b11 && head[7:0] == 8'd0) begin
          state_d = HOLD;
          rv_d    = 1'b1;
          rdata_d = 8'hFF;
          rerr_d  = 1'b1;
          rop_d   = head[17:16];
        end else begin
          state_d = ISSUE;
          start_d = 1'b1;
        end
      end
      ISSUE: state_d = SETTLE;
      SETTLE: begin
        state_d = WAIT;
        tmo_d   = '0;
      end
      WAIT: begin
        tmo_d = tmo_q + 1'b1;
        if (bus.alu_done || tmo_q == CW'(TIMEOUT-1)) begin
          state_d = HOLD;
          rv_d    = 1'b1;
          rop_d   = op_q;
          rerr_d  = !bus.alu_done;
          rdata_d = bus.alu_done ? bus.alu_result : 8'hFF;
        end
      end
      HOLD: if (rv_q && bus.res_ready) begin
        rv_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Upstream issue stage for the 8-bit multi-cycle ALU (add/sub/Booth mul/restoring div).
- Buffers operation commands in a small FIFO.
- Issues them one at a time on the ALU's start/opcode/operand interface and holds operands stable until done.
- Captures the 8-bit result into a valid/ready output register.
- Screens divide-by-zero and guards against a hung operation with a timeout.

Parameters:
DEPTH, 4, command FIFO entries (power of two, >=2)
TIMEOUT, 64, max cycles in WAIT before abort (>=40, covers 8-step mul/div)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO not full; command accepted on cmd_valid & cmd_ready
cmd_opcode  in  2  00 add, 01 sub, 10 mul, 11 div
cmd_a  in  8  operand A (dividend / multiplier)
cmd_b  in  8  operand B (divisor / multiplicand)
alu_start  out  1  one-cycle start pulse to ALU
alu_opcode  out  2  opcode to ALU
alu_a  out  8  operand A to ALU
alu_b  out  8  operand B to ALU
alu_done  in  1  ALU done flag
alu_result  in  8  ALU outbus
res_valid  out  1  result register holds data
res_ready  in  1  consumer accepts; transfer on res_valid & res_ready
res_data  out  8  result
res_opcode  out  2  opcode that produced res_data
res_err  out  1  1 = div-by-zero or timeout; res_data = 8'hFF

Behaviour:
- Reset (async, active-high): FIFO empty, state IDLE, timeout counter 0. Outputs: cmd_ready=1, alu_start=0, alu_opcode=0, alu_a=0, alu_b=0, res_valid=0, res_data=0, res_opcode=0, res_err=0. Reset mid-operation aborts it and discards queued commands and any pending result.
- FIFO:
  - cmd_ready = !full. A push when full is impossible (ready low).
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Read/write pointers wrap modulo DEPTH.
- FSM, all outputs registered:
  - IDLE: if FIFO non-empty and res_valid=0, pop the head into alu_opcode/alu_a/alu_b.
    - If opcode=11 and B=0: go to HOLD with res_data=FF, res_err=1, res_valid=1. No alu_start.
    - Otherwise go to ISSUE.
  - ISSUE (1 cycle): alu_start=1. Go to SETTLE.
  - SETTLE (1 cycle): alu_start=0. alu_done is ignored here, because it may still show the previous op. Go to WAIT; clear the timeout counter.
  - WAIT: counter increments each cycle.
    - alu_done=1: latch alu_result into res_data, res_err=0, res_valid=1, go to HOLD.
    - Else if counter reaches TIMEOUT-1: res_data=FF, res_err=1, res_valid=1, go to HOLD.
    - alu_done takes priority over timeout in the same cycle.
  - HOLD: when res_valid & res_ready, clear res_valid and go to IDLE. If the FIFO is non-empty in that same cycle, the pop is deferred to the next cycle (no IDLE bypass).
- alu_opcode/alu_a/alu_b stay stable from ISSUE until leaving WAIT, and keep their last value afterwards. res_opcode is loaded with alu_opcode at every res_valid set.
- Latency: for a command pushed at edge E0 into an empty FIFO while IDLE:
  - IDLE pops at E1; alu_start is high in the cycle after E1.
  - res_valid rises the edge after alu_done is first seen in WAIT.
- Throughput: one operation in flight; there is no new issue while a result is unconsumed.
- Result width is ALU outbus (8 bits). Mul returns the low product byte; div returns the quotient. No saturation.

Test Plan:
- Push add A=25,B=17 with res_ready=1 → exactly one alu_start pulse, alu_opcode=00; res_data=42, res_opcode=00, res_err=0.
- Push sub 10,3; mul 6,7; div 100,7 back-to-back → three start pulses in order; results 7, 42, 14 in order, each with correct res_opcode.
- Push div A=55,B=0 → no alu_start; res_valid with res_data=FF, res_err=1, res_opcode=11; the following queued add 1+1 still returns 2.
- res_ready=0, push DEPTH+2 commands → cmd_ready drops after DEPTH+1 accepts (DEPTH in FIFO, one popped); no second alu_start until res_ready=1; all results delivered in order.
- alu_done held 0 after start → res_err=1, res_data=FF exactly TIMEOUT cycles after entering WAIT; alu_done stuck at 1 from the previous op is ignored in SETTLE.
- Assert reset during WAIT with 2 queued commands → all outputs return to reset values the same cycle; no result is ever produced for the discarded commands.
